// File: rtl/cnn_layer_accel_job_pkg.sv
// Shared types and job-descriptor field layout for the quad job controller.
package cnn_layer_accel_job_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_CONFIG,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_EXEC,
    S_COMPLETE
  } job_state_t;

  localparam int unsigned JOB_PFB_LSB    = 0;
  localparam int unsigned JOB_PFB_W      = 10;
  localparam int unsigned JOB_STRIDE_LSB = 10;
  localparam int unsigned JOB_STRIDE_W   = 7;
  localparam int unsigned JOB_FMT_LSB    = 17;
  localparam int unsigned JOB_FMT_W      = 5;
  localparam int unsigned JOB_PAD_LSB    = 22;
  localparam int unsigned JOB_PAD_W      = 5;
  localparam int unsigned JOB_UPS_LSB    = 27;
  localparam int unsigned JOB_NKERN_LSB  = 28;
  localparam int unsigned JOB_NKERN_W    = 7;
  localparam int unsigned JOB_ROWS_LSB   = 35;
  localparam int unsigned JOB_ROWS_W     = 10;
  localparam int unsigned JOB_COLS_LSB   = 45;
  localparam int unsigned JOB_COLS_W     = 10;
  localparam int unsigned JOB_PIX_LSB    = 55;
  localparam int unsigned JOB_PIX_W      = 12;
  localparam int unsigned JOB_RSVD_LSB   = 67;

  function automatic logic rsvd_violation(input logic [127:0] p);
    return |p[127:JOB_RSVD_LSB];
  endfunction

endpackage

// File: rtl/cnn_layer_accel_cfg_lane_arb.sv
// Config-lane arbiter: lowest-index valid lane wins, per-lane word counters,
// registered one-hot write strobe and word address toward the lane config RAM.
module cnn_layer_accel_cfg_lane_arb
  import cnn_layer_accel_job_pkg::*;
#(
  parameter int unsigned NUM_CFG_LANES = 4,
  parameter int unsigned NUM_CFG_WORDS = 8,
  parameter int unsigned C_CFG_ADDR_W  = 3
) (
  input  logic                     clk_if,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     active,
  input  logic [NUM_CFG_LANES-1:0] config_valid,
  output logic [NUM_CFG_LANES-1:0] config_accept,
  output logic                     transfer,
  output logic                     all_full,
  output logic [NUM_CFG_LANES-1:0] cfg_wr_en,
  output logic [C_CFG_ADDR_W-1:0]  cfg_wr_addr
);

  localparam int unsigned CNT_W = C_CFG_ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_CFG_WORDS);

  logic [CNT_W-1:0]         lane_cnt [NUM_CFG_LANES];
  logic [NUM_CFG_LANES-1:0] grant;
  logic [C_CFG_ADDR_W-1:0]  grant_addr;
  logic                     blocked;

  // A lane that is eligible but sits above the winning lane sees accept low,
  // so valid & accept is always exactly the granted lane.
  always_comb begin
    grant         = '0;
    config_accept = '0;
    grant_addr    = '0;
    all_full      = 1'b1;
    blocked       = 1'b0;
    for (int unsigned i = 0; i < NUM_CFG_LANES; i++) begin
      if (lane_cnt[i] != CNT_FULL) all_full = 1'b0;
      if (active && (lane_cnt[i] < CNT_FULL) && !blocked) begin
        config_accept[i] = 1'b1;
        if (config_valid[i]) begin
          grant[i]   = 1'b1;
          grant_addr = lane_cnt[i][C_CFG_ADDR_W-1:0];
          blocked    = 1'b1;
        end
      end
    end
  end

  assign transfer = |grant;

  always_ff @(posedge clk_if or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CFG_LANES; i++) lane_cnt[i] <= '0;
      cfg_wr_en   <= '0;
      cfg_wr_addr <= '0;
    end else begin
      cfg_wr_en <= grant;
      if (transfer) cfg_wr_addr <= grant_addr;
      for (int unsigned i = 0; i < NUM_CFG_LANES; i++) begin
        if (clear)         lane_cnt[i] <= '0;
        else if (grant[i]) lane_cnt[i] <= lane_cnt[i] + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cnn_layer_accel_job_ctrl.sv
// Quad-side job/config handshake responder. Optional fetch/exec watchdog is
// compiled in with JOB_CTRL_TIMEOUT_EN.
module cnn_layer_accel_job_ctrl
  import cnn_layer_accel_job_pkg::*;
#(
  parameter int unsigned NUM_CFG_LANES  = 4,
  parameter int unsigned NUM_CFG_WORDS  = 8,
  parameter int unsigned C_CFG_ADDR_W   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk_if,
  input  logic                     rst_n,
  input  logic                     job_start,
  output logic                     job_accept,
  input  logic [127:0]             job_parameters,
  output logic                     job_fetch_request,
  input  logic                     job_fetch_ack,
  input  logic                     job_fetch_complete,
  output logic                     job_complete,
  input  logic                     job_complete_ack,
  input  logic [NUM_CFG_LANES-1:0] config_valid,
  output logic [NUM_CFG_LANES-1:0] config_accept,
  input  logic [127:0]             config_data,
  output logic [NUM_CFG_LANES-1:0] cfg_wr_en,
  output logic [C_CFG_ADDR_W-1:0]  cfg_wr_addr,
  output logic [127:0]             cfg_wr_data,
  output logic [9:0]               pfb_full_count_cfg,
  output logic [6:0]               stride_cfg,
  output logic [4:0]               conv_out_fmt_cfg,
  output logic [4:0]               padding_cfg,
  output logic                     upsample_cfg,
  output logic [6:0]               num_kernels_cfg,
  output logic [9:0]               num_output_rows_cfg,
  output logic [9:0]               num_output_cols_cfg,
  output logic [11:0]              pix_seq_data_full_count_cfg,
  output logic                     exec_start,
  input  logic                     exec_done,
  output logic                     job_error
);

  job_state_t state;
  logic       cfg_transfer;
  logic       cfg_all_full;
  logic       wd_hit;

  cnn_layer_accel_cfg_lane_arb #(
    .NUM_CFG_LANES (NUM_CFG_LANES),
    .NUM_CFG_WORDS (NUM_CFG_WORDS),
    .C_CFG_ADDR_W  (C_CFG_ADDR_W)
  ) u_lane_arb (
    .clk_if        (clk_if),
    .rst_n         (rst_n),
    .clear         (state == S_ACCEPT),
    .active        (state == S_CONFIG),
    .config_valid  (config_valid),
    .config_accept (config_accept),
    .transfer      (cfg_transfer),
    .all_full      (cfg_all_full),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_addr   (cfg_wr_addr)
  );

  always_ff @(posedge clk_if or negedge rst_n) begin
    if (!rst_n) begin
      cfg_wr_data <= '0;
    end else if (cfg_transfer) begin
      cfg_wr_data <= config_data;
    end
  end

`ifdef JOB_CTRL_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt;
  job_state_t  wd_state;
  logic        wd_armed;

  // wd_state lags state by one cycle; on the first cycle of a new state the
  // effective count is zero, so wd_cnt is trusted only once they agree.
  assign wd_armed = (state == S_FETCH_WAIT) || (state == S_EXEC);
  assign wd_hit   = wd_armed && (wd_state == state) && (wd_cnt == WD_LIMIT);

  always_ff @(posedge clk_if or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt   <= '0;
      wd_state <= S_IDLE;
    end else begin
      wd_state <= state;
      if (wd_state != state) wd_cnt <= 16'd1;
      else if (wd_armed)     wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk_if or negedge rst_n) begin
    if (!rst_n) begin
      state                       <= S_IDLE;
      job_accept                  <= 1'b0;
      job_fetch_request           <= 1'b0;
      job_complete                <= 1'b0;
      exec_start                  <= 1'b0;
      job_error                   <= 1'b0;
      pfb_full_count_cfg          <= '0;
      stride_cfg                  <= '0;
      conv_out_fmt_cfg            <= '0;
      padding_cfg                 <= '0;
      upsample_cfg                <= 1'b0;
      num_kernels_cfg             <= '0;
      num_output_rows_cfg         <= '0;
      num_output_cols_cfg         <= '0;
      pix_seq_data_full_count_cfg <= '0;
    end else begin
      job_accept <= 1'b0;
      exec_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (job_start) begin
            state                       <= S_ACCEPT;
            job_accept                  <= 1'b1;
            job_error                   <= rsvd_violation(job_parameters);
            pfb_full_count_cfg          <= job_parameters[JOB_PFB_LSB    +: JOB_PFB_W];
            stride_cfg                  <= job_parameters[JOB_STRIDE_LSB +: JOB_STRIDE_W];
            conv_out_fmt_cfg            <= job_parameters[JOB_FMT_LSB    +: JOB_FMT_W];
            padding_cfg                 <= job_parameters[JOB_PAD_LSB    +: JOB_PAD_W];
            upsample_cfg                <= job_parameters[JOB_UPS_LSB];
            num_kernels_cfg             <= job_parameters[JOB_NKERN_LSB  +: JOB_NKERN_W];
            num_output_rows_cfg         <= job_parameters[JOB_ROWS_LSB   +: JOB_ROWS_W];
            num_output_cols_cfg         <= job_parameters[JOB_COLS_LSB   +: JOB_COLS_W];
            pix_seq_data_full_count_cfg <= job_parameters[JOB_PIX_LSB    +: JOB_PIX_W];
          end
        end
        S_ACCEPT: begin
          if (NUM_CFG_WORDS == 0) begin
            state             <= S_FETCH_REQ;
            job_fetch_request <= 1'b1;
          end else begin
            state <= S_CONFIG;
          end
        end
        S_CONFIG: begin
          if (cfg_all_full) begin
            state             <= S_FETCH_REQ;
            job_fetch_request <= 1'b1;
          end
        end
        S_FETCH_REQ: begin
          if (job_fetch_ack) begin
            job_fetch_request <= 1'b0;
            // A completion arriving with the ack skips the wait state.
            if (job_fetch_complete) begin
              state      <= S_EXEC;
              exec_start <= 1'b1;
            end else begin
              state <= S_FETCH_WAIT;
            end
          end
        end
        S_FETCH_WAIT: begin
          if (wd_hit) begin
            state        <= S_COMPLETE;
            job_complete <= 1'b1;
            job_error    <= 1'b1;
          end else if (job_fetch_complete) begin
            state      <= S_EXEC;
            exec_start <= 1'b1;
          end
        end
        S_EXEC: begin
          if (wd_hit) begin
            state        <= S_COMPLETE;
            job_complete <= 1'b1;
            job_error    <= 1'b1;
          end else if (exec_done) begin
            state        <= S_COMPLETE;
            job_complete <= 1'b1;
          end
        end
        S_COMPLETE: begin
          if (job_complete_ack) begin
            state        <= S_IDLE;
            job_complete <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Directed bench for cnn_layer_accel_job_ctrl with a config-write scoreboard.
module tb_cnn_layer_accel_job_ctrl;

  localparam int unsigned LANES = 4;
  localparam int unsigned WORDS = 8;
  localparam int unsigned AW    = 3;

  logic             clk_if = 1'b0;
  logic             rst_n  = 1'b0;
  logic             job_start = 1'b0;
  logic             job_accept;
  logic [127:0]     job_parameters = '0;
  logic             job_fetch_request;
  logic             job_fetch_ack = 1'b0;
  logic             job_fetch_complete = 1'b0;
  logic             job_complete;
  logic             job_complete_ack = 1'b0;
  logic [LANES-1:0] config_valid = '0;
  logic [LANES-1:0] config_accept;
  logic [127:0]     config_data = '0;
  logic [LANES-1:0] cfg_wr_en;
  logic [AW-1:0]    cfg_wr_addr;
  logic [127:0]     cfg_wr_data;
  logic [9:0]       pfb_full_count_cfg;
  logic [6:0]       stride_cfg;
  logic [4:0]       conv_out_fmt_cfg;
  logic [4:0]       padding_cfg;
  logic             upsample_cfg;
  logic [6:0]       num_kernels_cfg;
  logic [9:0]       num_output_rows_cfg;
  logic [9:0]       num_output_cols_cfg;
  logic [11:0]      pix_seq_data_full_count_cfg;
  logic             exec_start;
  logic             exec_done = 1'b0;
  logic             job_error;

  always #5 clk_if = ~clk_if;

  cnn_layer_accel_job_ctrl #(
    .NUM_CFG_LANES  (LANES),
    .NUM_CFG_WORDS  (WORDS),
    .C_CFG_ADDR_W   (AW),
    .TIMEOUT_CYCLES (65535)
  ) dut (
    .clk_if                      (clk_if),
    .rst_n                       (rst_n),
    .job_start                   (job_start),
    .job_accept                  (job_accept),
    .job_parameters              (job_parameters),
    .job_fetch_request           (job_fetch_request),
    .job_fetch_ack               (job_fetch_ack),
    .job_fetch_complete          (job_fetch_complete),
    .job_complete                (job_complete),
    .job_complete_ack            (job_complete_ack),
    .config_valid                (config_valid),
    .config_accept               (config_accept),
    .config_data                 (config_data),
    .cfg_wr_en                   (cfg_wr_en),
    .cfg_wr_addr                 (cfg_wr_addr),
    .cfg_wr_data                 (cfg_wr_data),
    .pfb_full_count_cfg          (pfb_full_count_cfg),
    .stride_cfg                  (stride_cfg),
    .conv_out_fmt_cfg            (conv_out_fmt_cfg),
    .padding_cfg                 (padding_cfg),
    .upsample_cfg                (upsample_cfg),
    .num_kernels_cfg             (num_kernels_cfg),
    .num_output_rows_cfg         (num_output_rows_cfg),
    .num_output_cols_cfg         (num_output_cols_cfg),
    .pix_seq_data_full_count_cfg (pix_seq_data_full_count_cfg),
    .exec_start                  (exec_start),
    .exec_done                   (exec_done),
    .job_error                   (job_error)
  );

  typedef struct packed {
    logic [LANES-1:0] en;
    logic [AW-1:0]    addr;
    logic [127:0]     data;
  } wr_t;

  wr_t         sb[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned ex_cnt = 0;

  always @(negedge clk_if) if (exec_start) ex_cnt++;

  task automatic tick();
    @(posedge clk_if);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [9:0] pfb, input logic [6:0] st,
                                        input logic [4:0] fmt, input logic [4:0] pad,
                                        input logic up, input logic [6:0] nk,
                                        input logic [9:0] rows, input logic [9:0] cols,
                                        input logic [11:0] pix, input logic [60:0] rsvd);
    return {rsvd, pix, cols, rows, nk, up, pad, fmt, st, pfb};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {job_accept, job_fetch_request, job_complete, exec_start, job_error,
                           config_accept, cfg_wr_en, cfg_wr_addr}, '0);
    check({tag, "_wdata"}, cfg_wr_data, '0);
    check({tag, "_cfg"}, {pix_seq_data_full_count_cfg, num_output_cols_cfg, num_output_rows_cfg,
                          num_kernels_cfg, upsample_cfg, padding_cfg, conv_out_fmt_cfg,
                          stride_cfg, pfb_full_count_cfg}, '0);
  endtask

  task automatic start_job(input string tag, input logic [127:0] p);
    logic [66:0] fields;
    fields = p[66:0];
    job_start = 1'b1;
    job_parameters = p;
    tick();
    check({tag, "_accept"}, job_accept, 1);
    check({tag, "_fields"}, {pix_seq_data_full_count_cfg, num_output_cols_cfg, num_output_rows_cfg,
                             num_kernels_cfg, upsample_cfg, padding_cfg, conv_out_fmt_cfg,
                             stride_cfg, pfb_full_count_cfg}, fields);
    check({tag, "_err"}, job_error, (p[127:67] != '0));
    job_start = 1'b0;
    job_parameters = {$urandom, $urandom, $urandom, $urandom};
    tick();
    check({tag, "_accept_pulse"}, job_accept, 0);
    check({tag, "_fields_hold"}, {pix_seq_data_full_count_cfg, num_output_cols_cfg, num_output_rows_cfg,
                                  num_kernels_cfg, upsample_cfg, padding_cfg, conv_out_fmt_cfg,
                                  stride_cfg, pfb_full_count_cfg}, fields);
  endtask

  task automatic run_config(input string tag, input bit rnd);
    int unsigned      cnt [LANES];
    int unsigned      nfull;
    logic [LANES-1:0] v, win;
    logic [127:0]     d;
    wr_t              w;
    for (int i = 0; i < LANES; i++) cnt[i] = 0;
    nfull = 0;
    for (int cyc = 0; cyc < 400 && nfull < LANES; cyc++) begin
      v   = rnd ? LANES'($urandom) : '1;
      d   = {$urandom, $urandom, $urandom, $urandom};
      win = '0;
      for (int i = 0; i < LANES; i++) begin
        if (v[i] && cnt[i] < WORDS && win == '0) begin
          win[i] = 1'b1;
          sb.push_back('{en: win, addr: AW'(cnt[i]), data: d});
          cnt[i]++;
        end
      end
      config_valid = v;
      config_data  = d;
      #1;
      check({tag, "_xfer_lane"}, config_accept & v, win);
      tick();
      if (win != '0) begin
        w = sb.pop_front();
        check({tag, "_wr_en"}, cfg_wr_en, w.en);
        check({tag, "_wr_addr"}, cfg_wr_addr, w.addr);
        check({tag, "_wr_data"}, cfg_wr_data, w.data);
      end else begin
        check({tag, "_wr_idle"}, cfg_wr_en, '0);
      end
      nfull = 0;
      for (int i = 0; i < LANES; i++) if (cnt[i] == WORDS) nfull++;
    end
    check({tag, "_cfg_budget"}, nfull, LANES);
    config_valid = '1;
    #1;
    check({tag, "_full_no_accept"}, config_accept, '0);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_req_not_yet"}, job_fetch_request, 0);
    tick();
    config_valid = '0;
    check({tag, "_no_extra_wr"}, cfg_wr_en, '0);
    check({tag, "_req_rise"}, job_fetch_request, 1);
  endtask

  task automatic fetch_exec(input string tag, input int ack_delay, input bit same, input int done_delay);
    int unsigned ex0;
    ex0 = ex_cnt;
    repeat (ack_delay) begin
      tick();
      check({tag, "_req_held"}, job_fetch_request, 1);
    end
    job_fetch_ack = 1'b1;
    job_fetch_complete = same;
    tick();
    job_fetch_ack = 1'b0;
    job_fetch_complete = 1'b0;
    check({tag, "_req_drop"}, job_fetch_request, 0);
    if (!same) begin
      check({tag, "_no_early_start"}, exec_start, 0);
      repeat (2) begin
        tick();
        check({tag, "_wait_fetch"}, exec_start, 0);
      end
      job_fetch_complete = 1'b1;
      tick();
      job_fetch_complete = 1'b0;
    end
    check({tag, "_exec_start"}, exec_start, 1);
    repeat (done_delay) begin
      tick();
      check({tag, "_exec_busy"}, {exec_start, job_complete}, 2'b00);
    end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check({tag, "_complete"}, job_complete, 1);
    check({tag, "_start_pulse"}, exec_start, 0);
    check({tag, "_start_once"}, ex_cnt - ex0, 1);
  endtask

  task automatic finish_job(input string tag, input int hold);
    repeat (hold) begin
      tick();
      check({tag, "_complete_held"}, job_complete, 1);
    end
    job_complete_ack = 1'b1;
    tick();
    job_complete_ack = 1'b0;
    check({tag, "_complete_drop"}, job_complete, 0);
    check({tag, "_no_accept"}, job_accept, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] p;

    repeat (2) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Job 1: test-plan fields, all lanes valid, ack delayed, done on start cycle.
    p = pack(10'h1FF, 7'd2, 5'd3, 5'd1, 1'b0, 7'd16, 10'd28, 10'd28, 12'h310, '0);
    start_job("job1", p);
    check("job1_stride", stride_cfg, 2);
    check("job1_nkern", num_kernels_cfg, 16);
    check("job1_rows_cols", {num_output_rows_cfg, num_output_cols_cfg}, {10'd28, 10'd28});
    check("job1_pfb", pfb_full_count_cfg, 10'h1FF);
    run_config("job1", 1'b0);
    fetch_exec("job1", 5, 1'b0, 0);
    finish_job("job1", 10);

    // Job 2: reserved bit 100 set, random lane traffic, ack with fetch_complete.
    p = pack(10'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 1'b1, 7'($urandom),
             10'($urandom), 10'($urandom), 12'($urandom), 61'd1 << 33);
    start_job("job2", p);
    check("job2_err_set", job_error, 1);
    run_config("job2", 1'b1);
    fetch_exec("job2", 0, 1'b1, 3);
    check("job2_err_sticky", job_error, 1);
    finish_job("job2", 2);

    // Job 3: clean job clears the error, then reset lands mid-config.
    p = pack(10'd7, 7'd1, 5'd2, 5'd0, 1'b0, 7'd4, 10'd14, 10'd14, 12'd100, '0);
    start_job("job3", p);
    check("job3_err_clear", job_error, 0);
    config_valid = 4'b0001;
    repeat (3) begin
      config_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    check("job3_third_wr", {cfg_wr_en, cfg_wr_addr}, {4'b0001, 3'd2});
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    config_valid = '0;
    tick();
    check_reset_outputs("midreset_hold");
    rst_n = 1'b1;
    tick();

    // Job 4: fresh job after reset needs the full word count on every lane.
    p = pack(10'd300, 7'd3, 5'd9, 5'd2, 1'b1, 7'd64, 10'd56, 10'd112, 12'd2047, '0);
    start_job("job4", p);
    run_config("job4", 1'b0);
    fetch_exec("job4", 1, 1'b0, 2);
    finish_job("job4", 0);
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
